// File: rtl/parking_ctrl.sv
// parking_ctrl: multi-lane car-park occupancy controller.
//
// Counts cars over GATES entry/exit lane pairs. The count saturates at
// CAPACITY and at zero. Each entry request is granted or denied, and sensor
// faults are flagged. All outputs are registered, or are derived from the
// registered occupancy.
//
// Ports:
//   clk          in        rising-edge clock
//   rst          in        asynchronous active-high reset
//   entry        in  GATES per-lane entry loop sensor (level, synchronised)
//   exit         in  GATES per-lane exit loop sensor (level, synchronised)
//   num          out CW    current occupancy
//   free         out CW    CAPACITY - num
//   full         out       num == CAPACITY
//   empty        out       num == 0
//   entry_grant  out GATES one-cycle pulse: entry counted, open barrier
//   entry_deny   out GATES one-cycle pulse: entry refused, no space
//   exit_err     out GATES one-cycle pulse: exit ignored, no car to remove
//   conflict     out GATES one-cycle pulse: entry+exit edge on same lane, both ignored
module parking_ctrl #(
  parameter int CAPACITY = 10,
  parameter int INIT     = 5,
  parameter int GATES    = 2,
  parameter int CW       = $clog2(CAPACITY + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [GATES-1:0] entry,
  input  logic [GATES-1:0] exit,
  output logic [CW-1:0]    num,
  output logic [CW-1:0]    free,
  output logic             full,
  output logic             empty,
  output logic [GATES-1:0] entry_grant,
  output logic [GATES-1:0] entry_deny,
  output logic [GATES-1:0] exit_err,
  output logic [GATES-1:0] conflict
);

  // Event counts carry one extra bit so that room/xa/ea never wrap.
  localparam logic [CW:0]   CAP_X  = (CW+1)'(CAPACITY);
  localparam logic [CW:0]   ONE_X  = (CW+1)'(1);
  localparam logic [CW-1:0] CAP_N  = CW'(CAPACITY);
  localparam logic [CW-1:0] INIT_N = CW'(INIT);

  logic [CW-1:0]    num_q, num_d;
  logic [GATES-1:0] entry_q, entry_d;
  logic [GATES-1:0] exit_q, exit_d;
  logic [GATES-1:0] grant_q, grant_d;
  logic [GATES-1:0] deny_q, deny_d;
  logic [GATES-1:0] err_q, err_d;
  logic [GATES-1:0] conf_q, conf_d;

  logic [GATES-1:0] entry_ev, exit_ev;
  logic [CW:0]      xa, ea, room;

  always_comb begin
    entry_d  = entry;
    exit_d   = exit;
    entry_ev = entry & ~entry_q;
    exit_ev  = exit & ~exit_q;
    conf_d   = entry_ev & exit_ev;
    grant_d  = '0;
    deny_d   = '0;
    err_d    = '0;
    xa       = '0;
    ea       = '0;

    // Exits first, lowest lane wins, limited to the cars actually present.
    for (int g = 0; g < GATES; g++) begin
      if (exit_ev[g] && !conf_d[g]) begin
        if (xa < {1'b0, num_q}) xa = xa + ONE_X;
        else                    err_d[g] = 1'b1;
      end
    end

    // A space vacated this cycle can be handed straight to an entering car.
    room = CAP_X - {1'b0, num_q} + xa;

    for (int g = 0; g < GATES; g++) begin
      if (entry_ev[g] && !conf_d[g]) begin
        if (ea < room) begin
          ea         = ea + ONE_X;
          grant_d[g] = 1'b1;
        end else begin
          deny_d[g] = 1'b1;
        end
      end
    end

    // ea <= room guarantees the result stays within 0..CAPACITY.
    num_d = num_q + ea[CW-1:0] - xa[CW-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      num_q   <= INIT_N;
      // All-ones history: a sensor already high at reset release is not an edge.
      entry_q <= '1;
      exit_q  <= '1;
      grant_q <= '0;
      deny_q  <= '0;
      err_q   <= '0;
      conf_q  <= '0;
    end else begin
      num_q   <= num_d;
      entry_q <= entry_d;
      exit_q  <= exit_d;
      grant_q <= grant_d;
      deny_q  <= deny_d;
      err_q   <= err_d;
      conf_q  <= conf_d;
    end
  end

  assign num         = num_q;
  assign free        = CAP_N - num_q;
  assign full        = (num_q == CAP_N);
  assign empty       = (num_q == '0);
  assign entry_grant = grant_q;
  assign entry_deny  = deny_q;
  assign exit_err    = err_q;
  assign conflict    = conf_q;

endmodule

// File: tb/tb_parking_ctrl.sv
// Testbench for parking_ctrl: directed scenarios plus random sensor traffic.
// A queue-based reference model predicts each cycle's response. A separate
// monitor compares the DUT against that prediction one time unit after every
// rising edge.
module tb_parking_ctrl;

  localparam int CAP  = 10;
  localparam int INI  = 5;
  localparam int G    = 2;
  localparam int CWT  = $clog2(CAP + 1);

  logic           clk;
  logic           rst;
  logic [G-1:0]   entry, exit;
  logic [CWT-1:0] num, free;
  logic           full, empty;
  logic [G-1:0]   entry_grant, entry_deny, exit_err, conflict;

  parking_ctrl #(.CAPACITY(CAP), .INIT(INI), .GATES(G)) dut (
    .clk(clk), .rst(rst), .entry(entry), .exit(exit),
    .num(num), .free(free), .full(full), .empty(empty),
    .entry_grant(entry_grant), .entry_deny(entry_deny),
    .exit_err(exit_err), .conflict(conflict)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int           num;
    int           free;
    bit           full;
    bit           empty;
    logic [G-1:0] grant;
    logic [G-1:0] deny;
    logic [G-1:0] err;
    logic [G-1:0] conf;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state
  int       m_num;
  bit [G-1:0] m_prev_en, m_prev_ex;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic exp_t model_step(input bit r, input bit [G-1:0] en, input bit [G-1:0] ex);
    exp_t e;
    int xl[$];
    int el[$];
    int xa, ea, room;
    e.grant = '0; e.deny = '0; e.err = '0; e.conf = '0;
    if (r) begin
      m_num     = INI;
      m_prev_en = '1;
      m_prev_ex = '1;
    end else begin
      for (int g = 0; g < G; g++) begin
        bit re, rx;
        re = en[g] && !m_prev_en[g];
        rx = ex[g] && !m_prev_ex[g];
        if (re && rx) e.conf[g] = 1'b1;
        else begin
          if (rx) xl.push_back(g);
          if (re) el.push_back(g);
        end
      end
      xa = (xl.size() < m_num) ? xl.size() : m_num;
      foreach (xl[i]) if (i >= xa) e.err[xl[i]] = 1'b1;
      room = CAP - m_num + xa;
      ea = (el.size() < room) ? el.size() : room;
      foreach (el[i]) begin
        if (i < ea) e.grant[el[i]] = 1'b1;
        else        e.deny[el[i]]  = 1'b1;
      end
      m_num     = m_num + ea - xa;
      m_prev_en = en;
      m_prev_ex = ex;
    end
    e.num   = m_num;
    e.free  = CAP - m_num;
    e.full  = (m_num == CAP);
    e.empty = (m_num == 0);
    return e;
  endfunction

  task automatic drive(input bit r, input bit [G-1:0] en, input bit [G-1:0] ex);
    @(negedge clk);
    rst   = r;
    entry = en;
    exit  = ex;
    exp_q.push_back(model_step(r, en, ex));
  endtask

  // Monitor: the DUT presents a response every cycle.
  always begin
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      cmp("num",         32'(num),         32'(e.num));
      cmp("free",        32'(free),        32'(e.free));
      cmp("full",        32'(full),        32'(e.full));
      cmp("empty",       32'(empty),       32'(e.empty));
      cmp("entry_grant", 32'(entry_grant), 32'(e.grant));
      cmp("entry_deny",  32'(entry_deny),  32'(e.deny));
      cmp("exit_err",    32'(exit_err),    32'(e.err));
      cmp("conflict",    32'(conflict),    32'(e.conf));
    end
  end

  initial begin
    rst = 1'b1; entry = '0; exit = '0;
    m_num = INI; m_prev_en = '1; m_prev_ex = '1;

    // Reset, then a single entry on lane 0 (5 -> 6)
    drive(1, 2'b00, 2'b00);
    drive(1, 2'b00, 2'b00);
    drive(0, 2'b00, 2'b00);
    drive(0, 2'b01, 2'b00);
    drive(0, 2'b00, 2'b00);
    // Up to 9
    for (int i = 0; i < 3; i++) begin
      drive(0, 2'b01, 2'b00);
      drive(0, 2'b00, 2'b00);
    end
    // Fill to full with both lanes, then hold
    drive(0, 2'b11, 2'b00);
    drive(0, 2'b11, 2'b00);
    drive(0, 2'b11, 2'b00);
    drive(0, 2'b00, 2'b00);
    // Entry when full is denied
    drive(0, 2'b10, 2'b00);
    drive(0, 2'b00, 2'b00);
    // Swap at full
    drive(0, 2'b01, 2'b10);
    drive(0, 2'b00, 2'b00);
    // Drain to zero
    for (int i = 0; i < 10; i++) begin
      drive(0, 2'b00, 2'b01);
      drive(0, 2'b00, 2'b00);
    end
    // Underflow
    drive(0, 2'b00, 2'b11);
    drive(0, 2'b00, 2'b00);
    // Back to 5, then conflict on lane 1
    for (int i = 0; i < 5; i++) begin
      drive(0, 2'b01, 2'b00);
      drive(0, 2'b00, 2'b00);
    end
    drive(0, 2'b10, 2'b10);
    drive(0, 2'b00, 2'b00);
    // Reset mid-operation with entry[0] held
    drive(0, 2'b01, 2'b00);
    drive(1, 2'b01, 2'b00);
    drive(1, 2'b01, 2'b00);
    drive(0, 2'b01, 2'b00);
    drive(0, 2'b01, 2'b00);
    drive(0, 2'b01, 2'b00);
    drive(0, 2'b00, 2'b00);
    drive(0, 2'b01, 2'b00);
    drive(0, 2'b00, 2'b00);

    // Random traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      bit r;
      r = ($urandom_range(0, 199) == 0);
      drive(r, G'($urandom), G'($urandom));
    end
    drive(0, 2'b00, 2'b00);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
